// File: rtl/ro_pkg.sv
// +--------------------------------------------------------------------------+
// | ro_pkg: shared FSM encoding and default widths for the RO frequency meter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ro_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ro_edge_sync.sv
// +--------------------------------------------------------------------------+
// | ro_edge_sync: 2-flop synchroniser plus delay flop; one-cycle rise pulse   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ro_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rise = sync2_q & ~dly_q;

endmodule

`default_nettype wire

// File: rtl/ro_freq_meter.sv
// +--------------------------------------------------------------------------+
// | ro_freq_meter: counts ring-oscillator rising edges over a clk-cycle gate  |
// | window. Define RO_FREQ_CONT_EN for back-to-back continuous windows.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ro_freq_meter
  import ro_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_in,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             valid,
  input  logic             ready
);

  state_t             state_q;
  logic               busy_q;
  logic               valid_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic               rise;
  logic               cnt_full;
`ifdef RO_FREQ_CONT_EN
  logic [WIN_W-1:0]   win_len_q;
`endif

  ro_edge_sync u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .in    (ro_in),
    .rise  (rise)
  );

  assign cnt_full = &count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      win_cnt_q  <= '0;
`ifdef RO_FREQ_CONT_EN
      win_len_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (win_len != '0)) begin
            win_cnt_q  <= win_len;
`ifdef RO_FREQ_CONT_EN
            win_len_q  <= win_len;
`endif
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= GATE;
          end
        end
        GATE: begin
          // Saturate rather than wrap; overflow flags a lost edge.
          if (rise) begin
            if (cnt_full) overflow_q <= 1'b1;
            else          count_q    <= count_q + CNT_W'(1);
          end
          win_cnt_q <= win_cnt_q - WIN_W'(1);
          if (win_cnt_q == WIN_W'(1)) begin
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            valid_q <= 1'b0;
`ifdef RO_FREQ_CONT_EN
            win_cnt_q  <= win_len_q;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= GATE;
`else
            busy_q  <= 1'b0;
            state_q <= IDLE;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ro_freq_meter.sv
// +--------------------------------------------------------------------------+
// | tb_ro_freq_meter: self-checking bench for ro_freq_meter (16-bit and       |
// | 4-bit count instances side by side). Rev 1.0                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ro_freq_meter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] win_len;
  logic        ro_in;
  logic        ready;
  logic        busy,  busy4;
  logic [15:0] count;
  logic [3:0]  count4;
  logic        overflow, ovf4;
  logic        valid, valid4;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // Oscillator model: mode 0 static low, 1 fixed half period, 2 random.
  int ro_mode = 0;
  int ro_half = 4;
  int rises[$];

  ro_freq_meter u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .win_len  (win_len),
    .ro_in    (ro_in),
    .busy     (busy),
    .count    (count),
    .overflow (overflow),
    .valid    (valid),
    .ready    (ready)
  );

  ro_freq_meter #(.CNT_W(4), .WIN_W(16)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .win_len  (win_len),
    .ro_in    (ro_in),
    .busy     (busy4),
    .count    (count4),
    .overflow (ovf4),
    .valid    (valid4),
    .ready    (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int ph;
    int cur_half;
    ro_in    = 1'b0;
    ph       = 0;
    cur_half = 4;
    forever begin
      @(posedge clk);
      #1;
      if (ro_mode == 0) begin
        ro_in = 1'b0;
        ph    = 0;
      end else begin
        ph++;
        if (ph >= cur_half) begin
          ph    = 0;
          ro_in = ~ro_in;
          if (ro_in) rises.push_back(cyc);
          cur_half = (ro_mode == 2) ? int'($urandom_range(2, 6)) : ro_half;
        end
      end
    end
  end

  // A rise driven just after edge k is counted by the edge k+3.
  function automatic int rises_in(input int lo, input int hi);
    int c = 0;
    foreach (rises[i])
      if (rises[i] + 3 >= lo && rises[i] + 3 <= hi) c++;
    return c;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifndef RO_FREQ_CONT_EN
  task automatic run_meas(input int w, input int rdly, input bit poke);
    int t;
    int n;
    int k;
    win_len = 16'(w);
    start   = 1'b1;
    tick();
    t       = cyc;
    start   = 1'b0;
    win_len = 16'($urandom);
    chk("busy_at_start", 32'(busy), 32'd1);
    k = 0;
    while (valid !== 1'b1 && k < w + 8) begin
      tick();
      k++;
    end
    chk("valid_latency", 32'(cyc - t), 32'(w));
    chk("valid4", 32'(valid4), 32'd1);
    n = rises_in(t + 1, t + w);
    chk("count16", 32'(count), 32'(sat(n, 16)));
    chk("ovf16", 32'(overflow), 32'(n > 65535));
    chk("count4", 32'(count4), 32'(sat(n, 4)));
    chk("ovf4", 32'(ovf4), 32'(n > 15));
    for (int i = 0; i < rdly; i++) begin
      if (poke) begin
        start   = i[0];
        win_len = 16'd5;
      end
      tick();
    end
    start = 1'b0;
    if (rdly > 0) begin
      chk("hold_valid", 32'(valid), 32'd1);
      chk("hold_count", 32'(count), 32'(sat(n, 16)));
      chk("hold_busy", 32'(busy), 32'd1);
    end
    ready = 1'b1;
    start = poke;
    tick();
    ready = 1'b0;
    start = 1'b0;
    chk("post_valid", 32'(valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    if (poke) begin
      tick();
      chk("start_with_ready_ignored", 32'(busy), 32'd0);
    end
  endtask
`endif

  initial begin
    int t;
    int k;
    int s;
    int n;
    reset   = 1'b0;
    start   = 1'b0;
    win_len = '0;
    ready   = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    repeat (2) tick();

`ifndef RO_FREQ_CONT_EN
    // Edge every 8 clk over 80 cycles.
    ro_mode = 1; ro_half = 4;
    repeat (10) tick();
    run_meas(80, 0, 1'b0);

    // Edge every 4 clk over 100 cycles saturates the 4-bit instance.
    ro_half = 2;
    repeat (6) tick();
    run_meas(100, 0, 1'b0);
    chk("sat4_count", 32'(count4), 32'd15);
    chk("sat4_ovf", 32'(ovf4), 32'd1);

    // Backpressure with start pulses while holding.
    ro_mode = 2;
    run_meas(60, 20, 1'b1);

    // Zero-length window is ignored.
    win_len = '0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("win0_busy", 32'(busy), 32'd0);
    chk("win0_valid", 32'(valid), 32'd0);

    // One-cycle window with a static oscillator.
    ro_mode = 0;
    repeat (5) tick();
    run_meas(1, 0, 1'b0);
    chk("win1_count", 32'(count), 32'd0);

    // Reset in the middle of a gate window.
    ro_mode = 1; ro_half = 2;
    win_len = 16'd60;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    ro_mode = 0;
    repeat (5) tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_valid", 32'(valid), 32'd0);
    chk("async_ovf4", 32'(ovf4), 32'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", 32'(busy), 32'd0);
    ro_mode = 1; ro_half = 3;
    run_meas(30, 1, 1'b0);

    // Randomised measurements.
    ro_mode = 2;
    for (int r = 0; r < 8; r++)
      run_meas(int'($urandom_range(1, 150)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
`else
    // Continuous mode: back-to-back windows with ready held high.
    ro_mode = 1; ro_half = 4;
    repeat (10) tick();
    ready   = 1'b1;
    win_len = 16'd40;
    start   = 1'b1;
    tick();
    t     = cyc;
    start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      s = t + 41 * w;
      k = 0;
      while (valid !== 1'b1 && k < 50) begin
        tick();
        k++;
      end
      chk("cont_valid_time", 32'(cyc), 32'(s + 40));
      n = rises_in(s + 1, s + 40);
      chk("cont_count", 32'(count), 32'(sat(n, 16)));
      chk("cont_count4", 32'(count4), 32'(sat(n, 4)));
      tick();
      chk("cont_valid_drop", 32'(valid), 32'd0);
      chk("cont_busy", 32'(busy), 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
